// File: rtl/whirlpool_stream2matrix.sv
// whirlpool_stream2matrix: gathers a 512-bit block from IN_W-bit beats into the 8x8 Whirlpool byte matrix.
module whirlpool_stream2matrix #(
  parameter int IN_W = 64,
  parameter int TRANSPOSE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [0:IN_W-1] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_last,
  output logic [0:511]    out_matrix,
  output logic [6:0]      out_nbytes,
  output logic            out_valid,
  input  logic            out_ready
);
  localparam int BEATS = 512 / IN_W;
  localparam int NB = IN_W / 8;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic {FILL, FULL} state_t;
  state_t state, state_n;
  logic [0:511] fill_buf, placed;
  logic [CW-1:0] beat_cnt;
  logic [5:0] k, p;
  logic acc, close, ohs;
  logic [6:0] nb;
  assign acc = in_valid && in_ready;
  assign close = beat_cnt == CW'(BEATS - 1) || in_last;
  assign ohs = out_valid && out_ready;
  // beat_cnt is kept while FULL so the held block's byte count is still derivable
  assign nb = 7'((int'(beat_cnt) + 1) * NB);
  always_comb begin
    placed = fill_buf;
    k = '0;
    p = '0;
    for (int b = 0; b < NB; b++) begin
      k = 6'(int'(beat_cnt) * NB + b);
      p = TRANSPOSE != 0 ? {k[2:0], k[5:3]} : k;
      placed[8*p +: 8] = in_data[8*b +: 8];
    end
  end
  always_comb begin
    state_n = state;
    if (state == FILL)
      state_n = (acc && close && out_valid && !out_ready) ? FULL : FILL;
    else
      state_n = ohs ? FILL : FULL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      in_ready <= 1'b0;
      fill_buf <= '0;
      beat_cnt <= '0;
      out_matrix <= '0;
      out_nbytes <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      in_ready <= state_n == FILL;
      if (ohs) out_valid <= 1'b0;
      if (state == FILL && acc) begin
        if (!close) begin
          fill_buf <= placed;
          beat_cnt <= beat_cnt + 1'b1;
        end else if (!out_valid || out_ready) begin
          out_matrix <= placed;
          out_nbytes <= nb;
          out_valid <= 1'b1;
          fill_buf <= '0;
          beat_cnt <= '0;
        end else begin
          fill_buf <= placed;
        end
      end else if (state == FULL && ohs) begin
        out_matrix <= fill_buf;
        out_nbytes <= nb;
        out_valid <= 1'b1;
        fill_buf <= '0;
        beat_cnt <= '0;
      end
    end
  end
endmodule
